// File: rtl/pcf8591_sched.sv
// pcf8591_sched: shares one PCF8591 ADC/DAC between NREQ requesters.
// Requests are granted round-robin. Each grant becomes a fixed sequence of
// byte-level I2C commands for a byte master. The read byte or error goes back
// to the winning port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req/req_wr/req_ch/...    per-port request level, write flag, channel, DAC data
//   done/err/rdata           one-hot completion pulse, error flag, ADC result
//   busy                     transaction in progress (ARB..FIN)
//   cmd_valid/ready/cmd/...  command handshake towards the byte master
//   rsp_valid/nack/data      one response per accepted command
//   scan_data                auto-scan results, channel c in [8c+7:8c]
//
// Optional feature: define PCF8591_AUTOSCAN_EN to add a lowest-priority internal
// requester that reads channels 0..3 in turn every 2^20 cycles into scan_data.
// Without it scan_data is constant 0.
module pcf8591_sched #(
  parameter int unsigned NREQ     = 2,
  parameter logic [6:0]  DEV_ADDR = 7'b100_1000,
  parameter int unsigned TIMEOUT  = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_wr,
  input  logic [2*NREQ-1:0]   req_ch,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic [7:0]          rdata,
  output logic                busy,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [2:0]          cmd,
  output logic [7:0]          cmd_data,
  input  logic                rsp_valid,
  input  logic                rsp_nack,
  input  logic [7:0]          rsp_data,
  output logic [31:0]         scan_data
);

  localparam logic [2:0] CmdStart    = 3'd0;
  localparam logic [2:0] CmdWrite    = 3'd1;
  localparam logic [2:0] CmdReadAck  = 3'd2;
  localparam logic [2:0] CmdReadNack = 3'd3;
  localparam logic [2:0] CmdStop     = 3'd4;

  typedef enum logic [3:0] {
    StIdle, StArb, StS1, StAw, StCtrl, StDac, StS2, StAr, StDummy, StRd, StStop, StFin
  } state_e;

  state_e      state_q, state_d;
  logic        ph_q, ph_d;        // 0: offering command, 1: waiting for response
  logic [31:0] tmo_q, tmo_d;
  logic [1:0]  gnt_q, last_q;
  logic        gnt_scan_q;
  logic [1:0]  ch_q;
  logic        wr_q;
  logic [7:0]  wdata_q;
  logic        werr_q;
  logic [7:0]  wres_q;
  logic        err_q;
  logic [7:0]  rdata_q;

  logic        is_cmd, is_wr_st;
  logic        rsp_ok, nack_hit, tmo_hit, werr_nx, fin_entry;
  logic        arb_found;
  logic [1:0]  arb_idx, cand;
  logic        scan_pend, scan_win;
  logic [1:0]  scan_ch;
  logic [3:0]  req_x, wr_x, done_x;
  logic [7:0]  ch_x;
  logic [31:0] wd_x;

  assign req_x = 4'(req);
  assign wr_x  = 4'(req_wr);
  assign ch_x  = 8'(req_ch);
  assign wd_x  = 32'(req_wdata);

  // Round-robin: first set bit after the last granted index, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = 2'((32'(last_q) + i) % NREQ);
      if (!arb_found && req_x[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // The internal scanner only wins when no external port is requesting.
  assign scan_win = !arb_found && scan_pend;

  assign rsp_ok    = is_cmd && ph_q && rsp_valid;
  assign nack_hit  = rsp_ok && rsp_nack && is_wr_st;
  assign tmo_hit   = is_cmd && !rsp_ok && (tmo_q == TIMEOUT - 1);
  assign werr_nx   = werr_q | nack_hit | tmo_hit;
  assign fin_entry = (state_d == StFin) && (state_q != StFin);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|req || scan_pend) state_d = StArb;
      StArb:   state_d = (arb_found || scan_pend) ? StS1 : StIdle;
      StS1:    if (rsp_ok) state_d = StAw;
      StAw:    if (rsp_ok) state_d = rsp_nack ? StStop : StCtrl;
      StCtrl:  if (rsp_ok) state_d = rsp_nack ? StStop : (wr_q ? StDac : StS2);
      StDac:   if (rsp_ok) state_d = StStop;
      StS2:    if (rsp_ok) state_d = StAr;
      StAr:    if (rsp_ok) state_d = rsp_nack ? StStop : StDummy;
      StDummy: if (rsp_ok) state_d = StRd;
      StRd:    if (rsp_ok) state_d = StStop;
      StStop:  if (rsp_ok) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (tmo_hit) state_d = (state_q == StStop) ? StFin : StStop;

    // Phase and timeout counter restart on every state change.
    if (state_d != state_q) begin
      ph_d  = 1'b0;
      tmo_d = '0;
    end else begin
      ph_d  = ph_q | (cmd_valid & cmd_ready);
      tmo_d = is_cmd ? tmo_q + 32'd1 : '0;
    end
  end

  // Output / command decode
  always_comb begin
    is_cmd   = 1'b1;
    is_wr_st = 1'b0;
    cmd      = CmdStart;
    cmd_data = 8'h00;
    unique case (state_q)
      StS1, StS2: cmd = CmdStart;
      StAw: begin
        cmd = CmdWrite; is_wr_st = 1'b1; cmd_data = {DEV_ADDR, 1'b0};
      end
      StCtrl: begin
        // Bit 6 keeps the analog output enabled so the DAC holds across reads.
        cmd = CmdWrite; is_wr_st = 1'b1; cmd_data = 8'h40 | {6'b0, ch_q};
      end
      StDac: begin
        cmd = CmdWrite; is_wr_st = 1'b1; cmd_data = wdata_q;
      end
      StAr: begin
        cmd = CmdWrite; is_wr_st = 1'b1; cmd_data = {DEV_ADDR, 1'b1};
      end
      StDummy: cmd = CmdReadAck;
      StRd:    cmd = CmdReadNack;
      StStop:  cmd = CmdStop;
      default: is_cmd = 1'b0;
    endcase
    cmd_valid = is_cmd && !ph_q;
    busy      = (state_q != StIdle);
    done_x    = 4'b0001 << gnt_q;
    done      = (state_q == StFin && !gnt_scan_q) ? done_x[NREQ-1:0] : '0;
    err       = err_q;
    rdata     = rdata_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q       <= 1'b0;
      tmo_q      <= '0;
      gnt_q      <= '0;
      last_q     <= 2'(NREQ - 1);
      gnt_scan_q <= 1'b0;
      ch_q       <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      werr_q     <= 1'b0;
      wres_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ph_q  <= ph_d;
      tmo_q <= tmo_d;
      if (state_q == StArb) begin
        werr_q <= 1'b0;
        wres_q <= '0;
        if (arb_found) begin
          gnt_q      <= arb_idx;
          last_q     <= arb_idx;
          gnt_scan_q <= 1'b0;
          ch_q       <= ch_x[{arb_idx, 1'b0} +: 2];
          wr_q       <= wr_x[arb_idx];
          wdata_q    <= wd_x[{arb_idx, 3'b000} +: 8];
        end else if (scan_win) begin
          gnt_scan_q <= 1'b1;
          ch_q       <= scan_ch;
          wr_q       <= 1'b0;
          wdata_q    <= '0;
        end
      end
      if (nack_hit || tmo_hit) werr_q <= 1'b1;
      if (state_q == StRd && rsp_ok) wres_q <= rsp_data;
      if (fin_entry && !gnt_scan_q) begin
        err_q   <= werr_nx;
        rdata_q <= (werr_nx || wr_q) ? 8'h00 : wres_q;
      end
    end
  end

`ifdef PCF8591_AUTOSCAN_EN
  logic [19:0] scan_cnt_q;
  logic        scan_pend_q;
  logic [1:0]  scan_ch_q;
  logic [31:0] scan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      scan_pend_q <= 1'b0;
      scan_ch_q   <= '0;
      scan_q      <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_q + 20'd1;
      if (state_q == StArb && scan_win) scan_pend_q <= 1'b0;
      if (&scan_cnt_q) scan_pend_q <= 1'b1;
      if (fin_entry && gnt_scan_q) begin
        if (!werr_nx) scan_q[{ch_q, 3'b000} +: 8] <= wres_q;
        scan_ch_q <= scan_ch_q + 2'd1;
      end
    end
  end

  assign scan_pend = scan_pend_q;
  assign scan_ch   = scan_ch_q;
  assign scan_data = scan_q;
`else
  assign scan_pend = 1'b0;
  assign scan_ch   = 2'b00;
  assign scan_data = '0;
`endif

endmodule

// File: doc/pcf8591_sched.md
# pcf8591_sched

Transaction scheduler that shares one PCF8591 ADC/DAC between several requesters. It arbitrates round-robin between up to NREQ request ports. Each granted request becomes a fixed sequence of byte-level I2C commands (start, write, read, stop) for a byte-level I2C master, and the read byte or error is returned to the winning requester. It sits between the application logic (display, scanning, waveform output) and the I2C byte master that drives sda/scl.

## Interface
- NREQ, 2: number of requester ports (1..4).
- DEV_ADDR, 7'b100_1000: PCF8591 7-bit slave address.
- TIMEOUT, 1_000_000: clk cycles allowed per command response before abort.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request level; held until done.
- req_wr  in  NREQ  1 = DAC write, 0 = ADC read.
- req_ch  in  2*NREQ  ADC channel, slice [2k+1:2k] for port k.
- req_wdata  in  8*NREQ  DAC value, slice [8k+7:8k].
- done  out  NREQ  one-cycle completion pulse, one-hot.
- err  out  1  valid with done; 1 = NACK or timeout.
- rdata  out  8  ADC result, valid with done; 0 for writes or errors.
- busy  out  1  transaction in progress.
- cmd_valid  out  1  command to byte master.
- cmd_ready  in  1  byte master accepts the command.
- cmd  out  3  command code: 0 START (also used for repeated start), 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP.
- cmd_data  out  8  byte for WRITE.
- rsp_valid  in  1  one-cycle response, exactly one per accepted command.
- rsp_nack  in  1  slave NACK on WRITE; valid with rsp_valid.
- rsp_data  in  8  read byte; valid with rsp_valid.
- scan_data  out  32  auto-scan results, channel c in [8c+7:8c].

## Operation
- States: IDLE, ARB, S1, AW, CTRL, DAC, S2, AR, DUMMY, RD, STOP, FIN.
- IDLE: when any req bit is set, go to ARB.
- ARB: grant the first set bit after the last granted index, wrapping around. Latch the port's ch, wr and wdata. Go to S1.
- Command states: assert cmd_valid with fixed cmd/cmd_data until cmd_ready. Then deassert and wait for rsp_valid before the next state.
- Write sequence: S1 (START) → AW (WRITE {DEV_ADDR,0}) → CTRL (WRITE 8'h40 | ch) → DAC (WRITE wdata) → STOP → FIN.
- Read sequence: S1 → AW → CTRL → S2 (repeated START) → AR (WRITE {DEV_ADDR,1}) → DUMMY (READ_ACK, discarded; this byte is the previous conversion) → RD (READ_NACK, latched into the result) → STOP → FIN.
- Control byte always has bit6=1 (analog output enabled), so the DAC output holds its value across reads.
- rsp_nack=1 in AW, CTRL, DAC or AR: skip to STOP, set error flag.
- Timeout: a counter restarts on entry to each command state. If it reaches TIMEOUT with no rsp_valid, go to STOP with error. If STOP itself times out, go to FIN with error.
- FIN: pulse done[granted] and drive err/rdata for one cycle. Go to IDLE.
- A requester that drops req mid-transaction does not abort it; done still pulses.
- A request re-asserted in the cycle after its done waits behind every other pending requester.

## Timing
- Reset values: done=0, err=0, rdata=0, busy=0, cmd_valid=0, cmd=0, cmd_data=0, scan_data=0. Round-robin pointer resets so that port 0 wins first.
- IDLE→ARB→S1 takes 2 cycles. cmd_valid rises in the first cycle of S1.
- busy is 1 from ARB through FIN inclusive.
- rdata/err hold their values after the done pulse until the next FIN.
- rsp_valid arriving outside a wait phase is ignored.
- rst mid-transaction returns to IDLE next cycle with no STOP issued. The byte master shares rst and releases the bus.

## Configuration
- PCF8591_AUTOSCAN_EN defined: an internal requester at index NREQ sits at the lowest priority and is granted only when no external req is set. It issues an ADC read every 2^20 cycles, cycling channels 0→1→2→3→0. Each successful result updates the matching byte of scan_data. Errors leave scan_data unchanged. This requester never pulses done.
- Not defined: no internal requester, and scan_data is constant 0.

## Test plan
- ADC read: req[0]=1, ch=2; slave ACKs everything, dummy=8'h11, data=8'hA5 → command stream START, 90, 42, START, 91, READ_ACK, READ_NACK, STOP; done[0] pulses once, rdata=A5, err=0.
- DAC write: req[1]=1, wr=1, wdata=8'h80 → START, 90, 40, 80, STOP; done[1], rdata=0, err=0.
- Address NACK on the first WRITE → STOP issued next, with no further WRITE; done pulses, err=1, rdata=0.
- req=2'b11 held continuously for 4 transactions → grants alternate 0,1,0,1; exactly one done bit set per FIN.
- Byte master withholds rsp_valid after a WRITE → abort after exactly TIMEOUT cycles, STOP issued, err=1.
- Reset asserted during DUMMY → cmd_valid=0 and busy=0 next cycle, no done pulse; a new request then completes normally.
